// File: rtl/pipelined_control.sv
// Pipelined controller: decodes the ID opcode, carries control bundles through
// ID/EX, EX/MEM and MEM/WB, and resolves load-use stalls, taken branches and jumps.
module pipelined_control #(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   Opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_zero,
    output logic [1:0]            PCControl,
    output logic                  stall,
    output logic                  flush,
    output logic                  illegal,
    output logic                  RegDst,
    output logic                  ALUSrc,
    output logic                  Branch,
    output logic [ALUOP_W-1:0]    ALUOp,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  RegWrite,
    output logic                  MemtoReg
);

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    logic               opcode_hi;
    logic               dec_regdst, dec_alusrc, dec_branch;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_memwrite, dec_memread, dec_regwrite, dec_memtoreg;
    logic               dec_illegal, is_jump;

    logic               take, load_use, squash;

    logic               idex_regdst, idex_alusrc, idex_branch;
    logic [ALUOP_W-1:0] idex_aluop;
    logic               idex_memwrite, idex_memread, idex_regwrite, idex_memtoreg;
    logic               exmem_memwrite, exmem_memread, exmem_regwrite, exmem_memtoreg;
    logic               memwb_regwrite, memwb_memtoreg;

    // Any opcode bit above the low nibble makes the instruction undecodable
    assign opcode_hi = (Opcode >> 4) != '0;

    always_comb begin
        dec_regdst   = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_aluop    = '0;
        dec_memwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_illegal  = 1'b0;
        is_jump      = 1'b0;
        if (opcode_hi) begin
            dec_illegal = 1'b1;
        end else begin
            case (Opcode[3:0])
                4'd0: ;
                4'd1: begin
                    dec_regwrite = 1'b1;
                    dec_regdst   = 1'b1;
                    dec_aluop    = ALUOP_W'(2);
                end
                4'd2: begin
                    dec_regwrite = 1'b1;
                    dec_alusrc   = 1'b1;
                    dec_memread  = 1'b1;
                    dec_memtoreg = 1'b1;
                end
                4'd3: begin
                    dec_alusrc   = 1'b1;
                    dec_memwrite = 1'b1;
                end
                4'd4: begin
                    dec_branch = 1'b1;
                    dec_aluop  = ALUOP_W'(1);
                end
                4'd5: is_jump = 1'b1;
                4'd6: begin
                    dec_regwrite = 1'b1;
                    dec_alusrc   = 1'b1;
                end
                4'd7: begin
                    dec_regwrite = 1'b1;
                    dec_alusrc   = 1'b1;
                    dec_aluop    = ALUOP_W'(3);
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // A taken branch squashes the ID instruction, so it never needs to stall
    always_comb begin
        take      = idex_branch & ex_zero;
        load_use  = idex_memread & ((ex_rt == id_rs) || (ex_rt == id_rt));
        squash    = take | load_use;
        PCControl = PC_NEXT;
        stall     = 1'b0;
        flush     = 1'b0;
        if (!reset) begin
            if (take) begin
                PCControl = PC_BRANCH;
                flush     = 1'b1;
            end else if (load_use) begin
                PCControl = PC_HOLD;
                stall     = 1'b1;
            end else if (is_jump) begin
                PCControl = PC_JUMP;
                flush     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_regdst    <= 1'b0;
            idex_alusrc    <= 1'b0;
            idex_branch    <= 1'b0;
            idex_aluop     <= '0;
            idex_memwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            idex_regwrite  <= 1'b0;
            idex_memtoreg  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            memwb_regwrite <= 1'b0;
            memwb_memtoreg <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            idex_regdst    <= dec_regdst   & ~squash;
            idex_alusrc    <= dec_alusrc   & ~squash;
            idex_branch    <= dec_branch   & ~squash;
            idex_aluop     <= squash ? '0 : dec_aluop;
            idex_memwrite  <= dec_memwrite & ~squash;
            idex_memread   <= dec_memread  & ~squash;
            idex_regwrite  <= dec_regwrite & ~squash;
            idex_memtoreg  <= dec_memtoreg & ~squash;
            exmem_memwrite <= idex_memwrite;
            exmem_memread  <= idex_memread;
            exmem_regwrite <= idex_regwrite;
            exmem_memtoreg <= idex_memtoreg;
            memwb_regwrite <= exmem_regwrite;
            memwb_memtoreg <= exmem_memtoreg;
            illegal        <= dec_illegal & ~squash;
        end
    end

    assign RegDst   = idex_regdst;
    assign ALUSrc   = idex_alusrc;
    assign Branch   = idex_branch;
    assign ALUOp    = idex_aluop;
    assign MemWrite = exmem_memwrite;
    assign MemRead  = exmem_memread;
    assign RegWrite = memwb_regwrite;
    assign MemtoReg = memwb_memtoreg;

endmodule
